// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: single-outstanding AXI4 slave backed by a 2^MEM_AW x 32-bit memory.
// Rev 1.0
`default_nettype none

module axi4_mem_responder #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 34,
   parameter int C_AXI_ID_WIDTH   = 1,
   parameter int MEM_AW           = 8
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   // AW
   input  logic                          i_axi_awvalid,
   output logic                          o_axi_awready,
   input  logic [C_AXI_ID_WIDTH-1:0]     i_axi_awid,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_awaddr,
   input  logic [7:0]                    i_axi_awlen,
   input  logic [2:0]                    i_axi_awsize,
   input  logic [1:0]                    i_axi_awburst,
   input  logic                          i_axi_awlock,
   input  logic [3:0]                    i_axi_awcache,
   input  logic [2:0]                    i_axi_awprot,
   input  logic [3:0]                    i_axi_awqos,
   // W
   input  logic                          i_axi_wvalid,
   output logic                          o_axi_wready,
   input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_wdata,
   input  logic [C_AXI_DATA_WIDTH/8-1:0] i_axi_wstrb,
   input  logic                          i_axi_wlast,
   // B
   output logic                          o_axi_bvalid,
   input  logic                          i_axi_bready,
   output logic [C_AXI_ID_WIDTH-1:0]     o_axi_bid,
   output logic [1:0]                    o_axi_bresp,
   // AR
   input  logic                          i_axi_arvalid,
   output logic                          o_axi_arready,
   input  logic [C_AXI_ID_WIDTH-1:0]     i_axi_arid,
   input  logic [C_AXI_ADDR_WIDTH-1:0]   i_axi_araddr,
   input  logic [7:0]                    i_axi_arlen,
   input  logic [2:0]                    i_axi_arsize,
   input  logic [1:0]                    i_axi_arburst,
   input  logic                          i_axi_arlock,
   input  logic [3:0]                    i_axi_arcache,
   input  logic [2:0]                    i_axi_arprot,
   input  logic [3:0]                    i_axi_arqos,
   // R
   output logic                          o_axi_rvalid,
   input  logic                          i_axi_rready,
   output logic [C_AXI_ID_WIDTH-1:0]     o_axi_rid,
   output logic [C_AXI_DATA_WIDTH-1:0]   o_axi_rdata,
   output logic [1:0]                    o_axi_rresp,
   output logic                          o_axi_rlast
);

   localparam int         DEPTH       = 1 << MEM_AW;
   localparam int         NBYTES      = C_AXI_DATA_WIDTH / 8;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [2:0] SIZE_WORD   = 3'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WDATA = 2'd1,
      WRESP = 2'd2,
      RDATA = 2'd3
   } state_t;

   state_t                      state;
   state_t                      state_nxt;

   logic [C_AXI_DATA_WIDTH-1:0] mem [0:DEPTH-1];

   logic                        wr_prio;
   logic [MEM_AW-1:0]           addr;
   logic [MEM_AW-1:0]           addr_next;
   logic [MEM_AW-1:0]           rd_addr;
   logic [C_AXI_DATA_WIDTH-1:0] rd_word;
   logic [7:0]                  len;
   logic [7:0]                  cnt;
   logic [1:0]                  burst;
   logic                        size_ok;
   logic                        wlast_err;

   logic                        aw_hs;
   logic                        ar_hs;
   logic                        w_hs;
   logic                        r_hs;
   logic                        unused_ok;

   assign unused_ok = &{1'b0, i_axi_awlock, i_axi_awcache, i_axi_awprot, i_axi_awqos,
                        i_axi_arlock, i_axi_arcache, i_axi_arprot, i_axi_arqos,
                        i_axi_awaddr, i_axi_araddr};

   assign aw_hs = i_axi_awvalid & o_axi_awready;
   assign ar_hs = i_axi_arvalid & o_axi_arready;
   assign w_hs  = i_axi_wvalid  & o_axi_wready;
   assign r_hs  = o_axi_rvalid  & i_axi_rready;

   assign addr_next = (burst == BURST_FIXED) ? addr : addr + MEM_AW'(1);
   // Next read word: burst start on the AR handshake, otherwise the following beat.
   assign rd_addr   = ar_hs ? i_axi_araddr[MEM_AW+1:2] : addr_next;
   assign rd_word   = mem[rd_addr];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      o_axi_awready = 1'b0;
      o_axi_arready = 1'b0;
      o_axi_wready  = 1'b0;
      o_axi_bvalid  = 1'b0;
      o_axi_rvalid  = 1'b0;
      if (!i_reset) begin
         case (state)
            IDLE: begin
               if (i_axi_awvalid && (!i_axi_arvalid || wr_prio)) begin
                  o_axi_awready = 1'b1;
                  state_nxt     = WDATA;
               end else if (i_axi_arvalid) begin
                  o_axi_arready = 1'b1;
                  state_nxt     = RDATA;
               end
            end
            WDATA: begin
               o_axi_wready = 1'b1;
               if (i_axi_wvalid && (cnt == len)) begin
                  state_nxt = WRESP;
               end
            end
            WRESP: begin
               o_axi_bvalid = 1'b1;
               if (i_axi_bready) begin
                  state_nxt = IDLE;
               end
            end
            RDATA: begin
               o_axi_rvalid = 1'b1;
               if (i_axi_rready && o_axi_rlast) begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_prio     <= 1'b1;
         addr        <= '0;
         len         <= '0;
         cnt         <= '0;
         burst       <= '0;
         size_ok     <= 1'b0;
         wlast_err   <= 1'b0;
         o_axi_bid   <= '0;
         o_axi_bresp <= RESP_OKAY;
         o_axi_rid   <= '0;
         o_axi_rdata <= '0;
         o_axi_rresp <= RESP_OKAY;
         o_axi_rlast <= 1'b0;
      end else begin
         if (aw_hs) begin
            wr_prio   <= 1'b0;
            o_axi_bid <= i_axi_awid;
            addr      <= i_axi_awaddr[MEM_AW+1:2];
            len       <= i_axi_awlen;
            burst     <= i_axi_awburst;
            size_ok   <= (i_axi_awsize == SIZE_WORD);
            cnt       <= '0;
            wlast_err <= 1'b0;
         end

         if (ar_hs) begin
            wr_prio     <= 1'b1;
            o_axi_rid   <= i_axi_arid;
            addr        <= i_axi_araddr[MEM_AW+1:2];
            len         <= i_axi_arlen;
            burst       <= i_axi_arburst;
            size_ok     <= (i_axi_arsize == SIZE_WORD);
            cnt         <= '0;
            o_axi_rdata <= (i_axi_arsize == SIZE_WORD) ? rd_word : '0;
            o_axi_rresp <= (i_axi_arsize == SIZE_WORD) ? RESP_OKAY : RESP_SLVERR;
            o_axi_rlast <= (i_axi_arlen == 8'd0);
         end

         if (w_hs) begin
            cnt  <= cnt + 8'd1;
            addr <= addr_next;
            if (cnt == len) begin
               o_axi_bresp <= (size_ok && !wlast_err && i_axi_wlast) ? RESP_OKAY : RESP_SLVERR;
            end else if (i_axi_wlast) begin
               wlast_err <= 1'b1;
            end
         end

         if (r_hs) begin
            if (!o_axi_rlast) begin
               cnt         <= cnt + 8'd1;
               addr        <= addr_next;
               o_axi_rdata <= size_ok ? rd_word : '0;
               o_axi_rlast <= ((cnt + 8'd1) == len);
            end else begin
               o_axi_rlast <= 1'b0;
            end
         end
      end
   end

   // Memory array is deliberately outside the reset domain.
   always_ff @(posedge i_clk) begin
      if (w_hs && size_ok) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (i_axi_wstrb[b]) begin
               mem[addr][8*b +: 8] <= i_axi_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axi4_mem_responder.sv
// tb_axi4_mem_responder: directed + randomized checks against a word-array memory model.
// Rev 1.0
`default_nettype none

module tb_axi4_mem_responder;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_axi_awvalid, o_axi_awready, i_axi_awid;
   logic [33:0] i_axi_awaddr;
   logic [7:0]  i_axi_awlen;
   logic [2:0]  i_axi_awsize;
   logic [1:0]  i_axi_awburst;
   logic        i_axi_wvalid, o_axi_wready, i_axi_wlast;
   logic [31:0] i_axi_wdata;
   logic [3:0]  i_axi_wstrb;
   logic        o_axi_bvalid, i_axi_bready, o_axi_bid;
   logic [1:0]  o_axi_bresp;
   logic        i_axi_arvalid, o_axi_arready, i_axi_arid;
   logic [33:0] i_axi_araddr;
   logic [7:0]  i_axi_arlen;
   logic [2:0]  i_axi_arsize;
   logic [1:0]  i_axi_arburst;
   logic        o_axi_rvalid, i_axi_rready, o_axi_rid, o_axi_rlast;
   logic [31:0] o_axi_rdata;
   logic [1:0]  o_axi_rresp;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mdl [0:255];
   logic [31:0] wd  [0:255];
   logic [3:0]  ws  [0:255];

   always #5 clk = ~clk;

   axi4_mem_responder dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_axi_awvalid(i_axi_awvalid), .o_axi_awready(o_axi_awready), .i_axi_awid(i_axi_awid),
      .i_axi_awaddr(i_axi_awaddr), .i_axi_awlen(i_axi_awlen), .i_axi_awsize(i_axi_awsize),
      .i_axi_awburst(i_axi_awburst), .i_axi_awlock(1'b0), .i_axi_awcache(4'h3),
      .i_axi_awprot(3'd0), .i_axi_awqos(4'd0),
      .i_axi_wvalid(i_axi_wvalid), .o_axi_wready(o_axi_wready), .i_axi_wdata(i_axi_wdata),
      .i_axi_wstrb(i_axi_wstrb), .i_axi_wlast(i_axi_wlast),
      .o_axi_bvalid(o_axi_bvalid), .i_axi_bready(i_axi_bready), .o_axi_bid(o_axi_bid),
      .o_axi_bresp(o_axi_bresp),
      .i_axi_arvalid(i_axi_arvalid), .o_axi_arready(o_axi_arready), .i_axi_arid(i_axi_arid),
      .i_axi_araddr(i_axi_araddr), .i_axi_arlen(i_axi_arlen), .i_axi_arsize(i_axi_arsize),
      .i_axi_arburst(i_axi_arburst), .i_axi_arlock(1'b0), .i_axi_arcache(4'h3),
      .i_axi_arprot(3'd0), .i_axi_arqos(4'd0),
      .o_axi_rvalid(o_axi_rvalid), .i_axi_rready(i_axi_rready), .o_axi_rid(o_axi_rid),
      .o_axi_rdata(o_axi_rdata), .o_axi_rresp(o_axi_rresp), .o_axi_rlast(o_axi_rlast)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void mdl_wr(input int a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++)
         if (s[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
   endfunction

   function automatic int nxt(input int a, input int burst);
      return (burst == 0) ? a : (a + 1) % 256;
   endfunction

   task automatic set_aw(input logic [33:0] addr, input int len, input int burst, input int size, input int id);
      i_axi_awaddr = addr; i_axi_awlen = 8'(len); i_axi_awburst = 2'(burst);
      i_axi_awsize = 3'(size); i_axi_awid = 1'(id);
   endtask

   task automatic set_ar(input logic [33:0] addr, input int len, input int burst, input int size, input int id);
      i_axi_araddr = addr; i_axi_arlen = 8'(len); i_axi_arburst = 2'(burst);
      i_axi_arsize = 3'(size); i_axi_arid = 1'(id);
   endtask

   task automatic aw_hs();
      int n = 0;
      i_axi_awvalid = 1'b1; #1;
      while (!o_axi_awready && n < 50) begin @(posedge clk); #2; n++; end
      chk("aw_ready", o_axi_awready, 1);
      @(posedge clk); #1; i_axi_awvalid = 1'b0;
   endtask

   task automatic ar_hs();
      int n = 0;
      i_axi_arvalid = 1'b1; #1;
      while (!o_axi_arready && n < 50) begin @(posedge clk); #2; n++; end
      chk("ar_ready", o_axi_arready, 1);
      @(posedge clk); #1; i_axi_arvalid = 1'b0;
   endtask

   // Both channels request at once; checks which one the responder grants.
   task automatic arb(input bit exp_wr);
      i_axi_awvalid = 1'b1; i_axi_arvalid = 1'b1; #1;
      chk("arb_awready", o_axi_awready, 32'(exp_wr));
      chk("arb_arready", o_axi_arready, 32'(!exp_wr));
      @(posedge clk); #1;
      i_axi_awvalid = 1'b0; i_axi_arvalid = 1'b0;
   endtask

   task automatic write_txn(input logic [33:0] addr, input int len, input int burst, input int size,
                            input int id, input int wlast_beat, input bit do_aw, input int bstall,
                            input int abort_at);
      int a; int n;
      logic [1:0] er;
      if (do_aw) begin set_aw(addr, len, burst, size, id); aw_hs(); end
      a = int'(addr[9:2]);
      for (int b = 0; b <= len; b++) begin
         if (b == abort_at) begin
            i_axi_wvalid = 1'b0; i_reset = 1'b1;
            @(posedge clk); #1; i_reset = 1'b0;
            chk("wabort_bvalid", o_axi_bvalid, 0);
            chk("wabort_wready", o_axi_wready, 0);
            return;
         end
         i_axi_wvalid = 1'b1; i_axi_wdata = wd[b]; i_axi_wstrb = ws[b];
         i_axi_wlast = (b == wlast_beat);
         n = 0; #1;
         while (!o_axi_wready && n < 50) begin @(posedge clk); #2; n++; end
         chk("w_ready", o_axi_wready, 1);
         @(posedge clk); #1;
         if (size == 2) mdl_wr(a, wd[b], ws[b]);
         a = nxt(a, burst);
      end
      i_axi_wvalid = 1'b0; i_axi_wlast = 1'b0;
      er = (size == 2 && wlast_beat == len) ? 2'b00 : 2'b10;
      for (int k = 0; k < bstall; k++) begin
         #1;
         chk("b_valid_hold", o_axi_bvalid, 1);
         chk("b_id_hold", o_axi_bid, 32'(id & 1));
         @(posedge clk); #1;
      end
      i_axi_bready = 1'b1; #1;
      chk("b_valid", o_axi_bvalid, 1);
      chk("b_id", o_axi_bid, 32'(id & 1));
      chk("b_resp", o_axi_bresp, er);
      @(posedge clk); #1;
      chk("b_done", o_axi_bvalid, 0);
      i_axi_bready = 1'b0;
   endtask

   // mode 0: rready always high, 1: toggling 1/0, 2: random.
   task automatic read_txn(input logic [33:0] addr, input int len, input int burst, input int size,
                           input int id, input int mode, input bit do_ar, input int abort_at);
      int a; int beat; int n;
      if (do_ar) begin set_ar(addr, len, burst, size, id); ar_hs(); end
      a = int'(addr[9:2]); beat = 0; n = 0;
      chk("r_first_valid", o_axi_rvalid, 1);
      while (beat <= len && n < 3000) begin
         if (beat == abort_at) begin
            i_axi_rready = 1'b0; i_reset = 1'b1;
            @(posedge clk); #1; i_reset = 1'b0;
            chk("rabort_rvalid", o_axi_rvalid, 0);
            chk("rabort_rlast", o_axi_rlast, 0);
            chk("rabort_rdata", o_axi_rdata, 0);
            return;
         end
         case (mode)
            0:       i_axi_rready = 1'b1;
            1:       i_axi_rready = (n % 2 == 0);
            default: i_axi_rready = 1'($urandom_range(0, 1));
         endcase
         #1;
         chk("r_valid", o_axi_rvalid, 1);
         chk("r_id", o_axi_rid, 32'(id & 1));
         chk("r_data", o_axi_rdata, (size == 2) ? mdl[a] : 32'h0);
         chk("r_resp", o_axi_rresp, (size == 2) ? 32'h0 : 32'h2);
         chk("r_last", o_axi_rlast, 32'(beat == len));
         @(posedge clk); #1;
         if (i_axi_rready) begin beat++; a = nxt(a, burst); end
         n++;
      end
      i_axi_rready = 1'b0;
      chk("r_done", o_axi_rvalid, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [33:0] ra;
      int len, burst, size, wlb;

      i_reset = 1'b1;
      i_axi_awvalid = 1'b1; i_axi_arvalid = 1'b1; i_axi_wvalid = 1'b1;
      i_axi_bready = 1'b0; i_axi_rready = 1'b0;
      set_aw(0, 0, 1, 2, 0); set_ar(0, 0, 1, 2, 0);
      i_axi_wdata = '0; i_axi_wstrb = '0; i_axi_wlast = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", o_axi_awready, 0);
      chk("rst_arready", o_axi_arready, 0);
      chk("rst_wready", o_axi_wready, 0);
      chk("rst_bvalid", o_axi_bvalid, 0);
      chk("rst_rvalid", o_axi_rvalid, 0);
      chk("rst_rlast", o_axi_rlast, 0);
      chk("rst_bid", o_axi_bid, 0);
      chk("rst_rid", o_axi_rid, 0);
      chk("rst_bresp", o_axi_bresp, 0);
      chk("rst_rresp", o_axi_rresp, 0);
      chk("rst_rdata", o_axi_rdata, 0);
      i_axi_awvalid = 1'b0; i_axi_arvalid = 1'b0;
      i_reset = 1'b0;

      // W beats offered before any AW are refused.
      repeat (3) begin
         #1; chk("w_before_aw", o_axi_wready, 0);
         @(posedge clk); #1;
      end
      i_axi_wvalid = 1'b0;

      // Fill the whole memory with one 256-beat burst.
      for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      write_txn(34'h0, 255, 1, 2, 0, 255, 1, 2, -1);

      // Reset restores write priority for the arbitration sequence.
      i_reset = 1'b1; @(posedge clk); #1; i_reset = 1'b0;

      for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
      set_aw(34'h10, 3, 1, 2, 1); set_ar(34'h10, 3, 1, 2, 1);
      arb(1'b1);
      write_txn(34'h10, 3, 1, 2, 1, 3, 0, 1, -1);
      set_ar(34'h10, 3, 1, 2, 1);
      arb(1'b0);
      read_txn(34'h10, 3, 1, 2, 1, 0, 0, -1);
      for (int b = 0; b < 2; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      set_aw(34'h80, 1, 1, 2, 0); set_ar(34'h80, 1, 1, 2, 0);
      arb(1'b1);
      write_txn(34'h80, 1, 1, 2, 0, 1, 0, 0, -1);
      set_ar(34'h80, 1, 1, 2, 0);
      arb(1'b0);
      read_txn(34'h80, 1, 1, 2, 0, 2, 0, -1);

      // Byte strobes over a zeroed word.
      wd[0] = 32'h0; ws[0] = 4'hF;
      write_txn(34'h40, 0, 1, 2, 0, 0, 1, 0, -1);
      wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
      write_txn(34'h40, 0, 1, 2, 1, 0, 1, 0, -1);
      read_txn(34'h40, 0, 1, 2, 1, 0, 1, -1);

      // Address wrap 255 -> 0 with a stalling reader.
      for (int b = 0; b < 2; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      write_txn(34'h3FC, 1, 1, 2, 0, 1, 1, 0, -1);
      read_txn(34'h3FC, 1, 1, 2, 0, 1, 1, -1);

      // Early wlast, narrow read, narrow write.
      for (int b = 0; b < 3; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      write_txn(34'h20, 2, 1, 2, 0, 1, 1, 0, -1);
      read_txn(34'h20, 2, 1, 1, 0, 0, 1, -1);
      write_txn(34'h24, 1, 1, 1, 1, 1, 1, 1, -1);
      read_txn(34'h24, 1, 1, 2, 1, 0, 1, -1);

      // FIXED and WRAP bursts.
      for (int b = 0; b < 5; b++) begin wd[b] = $urandom; ws[b] = 4'(1 << (b % 4)) | 4'h1; end
      write_txn(34'h60, 3, 0, 2, 0, 3, 1, 0, -1);
      read_txn(34'h60, 2, 0, 2, 0, 2, 1, -1);
      write_txn(34'h3F8, 4, 2, 2, 1, 4, 1, 0, -1);
      read_txn(34'h3F8, 4, 2, 2, 1, 1, 1, -1);

      // Reset mid-write keeps completed beats; reset mid-read aborts.
      for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      write_txn(34'h100, 3, 1, 2, 0, 3, 1, 0, 2);
      read_txn(34'h100, 3, 1, 2, 0, 0, 1, -1);
      read_txn(34'h10, 3, 1, 2, 0, 0, 1, 1);
      read_txn(34'h30, 2, 1, 2, 1, 0, 1, -1);

      repeat (16) begin
         ra[31:0]  = $urandom;
         ra[33:32] = 2'($urandom_range(0, 3));
         len   = int'($urandom_range(0, 15));
         burst = int'($urandom_range(0, 2));
         size  = ($urandom_range(0, 7) == 0) ? 1 : 2;
         wlb   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : len;
         for (int b = 0; b <= len; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
         write_txn(ra, len, burst, size, int'($urandom_range(0, 1)), wlb, 1,
                   int'($urandom_range(0, 2)), -1);
         ra[31:0] = $urandom;
         read_txn(ra, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 7) == 0) ? 1 : 2, int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)), 1, -1);
      end

      read_txn(34'h0, 255, 1, 2, 0, 2, 1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
